rob_commit: RTL

- In-order retirement stage at the read end of the reorder buffer.
- Each cycle it examines up to INSTR_COUNT head entries and drives a thermometer pop vector back to the ROB.
- It queues the physical destination register of every retired instruction in an internal release FIFO, which drains one register per cycle to the free list over a valid/ready handshake.
- It also supports a halt/drain request for pipeline flush sequencing.

---
 rtl/rob_pkg.sv | 15 +
 rtl/rob_commit_rel_fifo.sv | 67 ++++++
 rtl/rob_commit.sv | 103 ++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// Shared types and default sizes for the ROB commit stage.
package rob_pkg;

  localparam int unsigned DEF_INSTR_COUNT  = 2;
  localparam int unsigned DEF_P_ADDR_WIDTH = 7;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } commit_state_t;

  typedef logic [DEF_P_ADDR_WIDTH-1:0] preg_t;

endpackage

// File: rtl/rob_commit_rel_fifo.sv
// Release FIFO: up to LANES in-order pushes per cycle (compacted), one pop per cycle,
// registered head value and valid.
module rel_fifo
  import rob_pkg::*;
#(
  parameter int unsigned LANES = DEF_INSTR_COUNT,
  parameter int unsigned WIDTH = DEF_P_ADDR_WIDTH,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [LANES-1:0]       push_en,
  input  logic [LANES*WIDTH-1:0] push_data,
  input  logic                   pop,
  output logic                   head_valid,
  output logic [WIDTH-1:0]       head_data,
  output logic [CNT_W-1:0]       count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_n [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_n, wr_q, wr_n;
  logic [CNT_W-1:0] cnt_q, cnt_n, n_push;
  logic             deq;

  // Enabled lanes land at consecutive write slots, lowest lane first.
  always_comb begin
    mem_n  = mem_q;
    wr_n   = wr_q;
    n_push = '0;
    deq    = pop & head_valid;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (push_en[i]) begin
        mem_n[wr_n] = push_data[i*WIDTH +: WIDTH];
        wr_n        = wr_n + PTR_W'(1);
        n_push      = n_push + CNT_W'(1);
      end
    end
    rd_n  = rd_q + PTR_W'(deq);
    cnt_n = cnt_q + n_push - CNT_W'(deq);
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
      head_valid <= 1'b0;
      head_data  <= '0;
    end else begin
      rd_q       <= rd_n;
      wr_q       <= wr_n;
      cnt_q      <= cnt_n;
      head_valid <= (cnt_n != '0);
      head_data  <= mem_n[rd_n];
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/rob_commit.sv
// In-order retirement at the ROB head: thermometer pop, physical register release
// queue toward the free list, halt/drain sequencing and a retired-instruction counter.
module rob_commit
  import rob_pkg::*;
#(
  parameter int unsigned INSTR_COUNT  = DEF_INSTR_COUNT,
  parameter int unsigned P_ADDR_WIDTH = DEF_P_ADDR_WIDTH,
  parameter int unsigned REL_DEPTH    = 8,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [INSTR_COUNT-1:0]            rob_valid,
  input  logic [INSTR_COUNT-1:0]            rob_exec,
  input  logic [INSTR_COUNT*P_ADDR_WIDTH-1:0] rob_ppdst,
  output logic [INSTR_COUNT-1:0]            rob_pop,
  output logic                              rel_valid,
  output logic [P_ADDR_WIDTH-1:0]           rel_preg,
  input  logic                              rel_ready,
  input  logic                              halt_req,
  output logic                              halted,
  output logic [CNT_WIDTH-1:0]              commit_cnt
);

  localparam int unsigned FCNT_W = $clog2(REL_DEPTH + 1);
  localparam int unsigned POP_W  = $clog2(INSTR_COUNT + 1);

  commit_state_t          state_q, state_n;
  logic [INSTR_COUNT-1:0] ok;
  logic [INSTR_COUNT-1:0] push_en;
  logic [FCNT_W-1:0]      fifo_count;
  logic                   space;
  logic [POP_W-1:0]       n_retire;

  // Prefix AND keeps retirement in order: a younger entry needs every older one ready.
  always_comb begin
    ok    = '0;
    ok[0] = rob_valid[0] & rob_exec[0];
    for (int unsigned i = 1; i < INSTR_COUNT; i++) begin
      ok[i] = ok[i-1] & rob_valid[i] & rob_exec[i];
    end
  end

  // Worst-case room for a full commit group, from the registered count only.
  assign space = (fifo_count <= FCNT_W'(REL_DEPTH - INSTR_COUNT));

  always_comb begin
    state_n = state_q;
    rob_pop = '0;
    case (state_q)
      RUN: begin
        if (space && rst_n) rob_pop = ok;
        if (halt_req) state_n = DRAIN;
      end
      DRAIN: begin
        if (!halt_req)              state_n = RUN;
        else if (fifo_count == '0)  state_n = HALTED;
      end
      HALTED: begin
        if (!halt_req) state_n = RUN;
      end
      default: state_n = RUN;
    endcase
  end

  // Register 0 is architecturally pinned, so it is retired but never released.
  always_comb begin
    push_en  = '0;
    n_retire = '0;
    for (int unsigned i = 0; i < INSTR_COUNT; i++) begin
      push_en[i] = rob_pop[i] & (rob_ppdst[i*P_ADDR_WIDTH +: P_ADDR_WIDTH] != '0);
      n_retire   = n_retire + POP_W'(rob_pop[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      halted     <= 1'b0;
      commit_cnt <= '0;
    end else begin
      state_q    <= state_n;
      halted     <= (state_n == HALTED);
      commit_cnt <= commit_cnt + CNT_WIDTH'(n_retire);
    end
  end

  rel_fifo #(
    .LANES (INSTR_COUNT),
    .WIDTH (P_ADDR_WIDTH),
    .DEPTH (REL_DEPTH)
  ) u_rel_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_en    (push_en),
    .push_data  (rob_ppdst),
    .pop        (rel_ready),
    .head_valid (rel_valid),
    .head_data  (rel_preg),
    .count      (fifo_count)
  );

endmodule
